lane_done_sync: RTL and testbench
=================================

# lane_done_sync

Per-channel completion aligner between the `NrLane` lane instances and `vinsn_launcher`. It collects the one-cycle done pulses each lane raises for every lane VFU and every operand queue, and holds them until all lanes have reported. It then emits a single registered, lane-agnostic done pulse per channel. This replaces the lane-0-only forwarding of done/id/vd signals, so lanes that finish on different cycles can no longer cause early or lost completions. It also flags protocol violations.

## Interface
Parameters:
- `NumLane`, default `NrLane`: number of lanes aggregated.
- `NumVFU`, default `NrLaneVFU`: VFU done channels per lane.
- `NumOpQ`, default `NrOpQueue`: operand-access done channels per lane.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `lane_vfus_done_i`  in  `[NumLane][NumVFU]`  per-lane VFU done pulses.
- `lane_vfus_done_id_i`  in  `insn_id_t [NumLane][NumVFU]`  instruction ID accompanying each done.
- `lane_vfus_use_vd_i`  in  `[NumLane][NumVFU]`  instruction writes vd.
- `lane_vfus_vd_i`  in  `vreg_t [NumLane][NumVFU]`  destination register.
- `lane_op_access_done_i`  in  `[NumLane][NumOpQ]`  per-lane operand-access done pulses.
- `lane_op_access_vs_i`  in  `vreg_t [NumLane][NumOpQ]`  source register read.
- `vfus_done_o`  out  `[NumVFU]`  aligned done pulse, one cycle wide.
- `vfus_done_id_o`  out  `insn_id_t [NumVFU]`  ID for the pulse; held until the next pulse.
- `vfus_use_vd_o`  out  `[NumVFU]`  use_vd for the pulse; held.
- `vfus_vd_o`  out  `vreg_t [NumVFU]`  vd for the pulse; held.
- `op_access_done_o`  out  `[NumOpQ]`  aligned operand-access done pulse.
- `op_access_vs_o`  out  `vreg_t [NumOpQ]`  vs for the pulse; held.
- `err_overrun_o`  out  `[NumVFU+NumOpQ]`  sticky: a lane reported twice before its channel completed. VFU channels occupy the low bits.
- `err_mismatch_o`  out  `[NumVFU+NumOpQ]`  sticky: a lane's ID/vd/vs differed from the latched value.

## Operation
- Each of the `NumVFU+NumOpQ` channels is independent. Per channel the state is:
  - a `NumLane`-bit `pending` vector;
  - a `busy` flag;
  - latched payload: ID, use_vd and vd for VFU channels, or vs for OpQ channels.
- Channel state machine: IDLE (`busy=0`) and COLLECT (`busy=1`).
- IDLE with at least one lane reporting:
  - Latch the payload of the lowest-indexed reporting lane.
  - Set `pending` bits for all reporting lanes.
  - If all lanes are now set, complete; otherwise go to COLLECT.
- COLLECT with lane k reporting:
  - If `pending[k]=0`, set it.
  - If `pending[k]=1`, set the overrun error bit and ignore the report; it does not count toward completion.
- Mismatch check:
  - The payload of each counted report is compared with the latched payload. For reports arriving in the IDLE cycle, compare against the lowest-indexed lane's payload.
  - Any difference sets the mismatch bit. The report still counts toward completion, and the latched payload is kept.
- Completion condition: `pending | counted_arrivals` equals all ones.
- On completion, in the same edge:
  - Assert the channel done output for the next cycle.
  - Drive the latched payload on the outputs.
  - Clear `pending`, return to IDLE.
- A fresh report one cycle after completion starts a new collection normally.
- The use_vd bit is compared and carried only for VFU channels. vd is compared only when use_vd=1.
- Error bits stay set until reset. They never block operation.

## Timing
- Latency: done output rises exactly 1 cycle after the edge on which the last lane's report is sampled. With all lanes in the same cycle, the pulse appears on the following cycle.
- Done outputs are registered, high for exactly one cycle per completion. Back-to-back completions on one channel give pulses on consecutive cycles.
- Payload outputs are registered. They change only in the cycle their done pulse is asserted and hold afterwards.
- Reset (`rst_ni=0` at an edge):
  - All outputs are 0: done, id, use_vd, vd, vs and both error vectors.
  - All `pending` and `busy` state is cleared.
  - Reset mid-collection discards partial reports; no pulse is emitted for them.
  - Inputs sampled during reset are ignored.
- No combinational path from any input to any output.

## Test plan
- NumLane=4, VFU0: lanes 0..3 all pulse with id=5, vd=3, use_vd=1 in cycle 10 -> `vfus_done_o[0]=1` in cycle 11 only, id=5, vd=3; no errors.
- Staggered reports: lanes report OpQ1 (vs=7) in cycles 10, 12, 12, 15 -> `op_access_done_o[1]` pulses only in cycle 16 with vs=7; no pulse in cycles 11–15.
- Overrun: lane 2 reports VFU1 in cycles 4 and 6, other lanes in cycle 8 -> pulse in cycle 9; `err_overrun_o[1]=1` from cycle 7 and remains 1.
- Mismatch: lane 0 reports id=2 and lane 3 reports id=4 in the same cycle, all other lanes id=2 -> pulse with id=2; `err_mismatch_o[VFU index]=1`.
- Back-to-back: all lanes report VFU0 id=1 in cycle 3 and id=2 in cycle 4 -> pulses in cycles 4 (id=1) and 5 (id=2); no errors.
- Reset mid-operation: lanes 0–1 report VFU2, `rst_ni=0` for one cycle, then lanes 2–3 report -> no pulse; all outputs 0 after the reset edge; `pending` shows lanes 2–3 only.

Source files
------------

// File: rtl/lane_done_sync.sv
// lane_done_sync: per-channel completion aligner. Collects one-cycle done
// pulses from every lane for each VFU and operand-queue channel, and emits a
// single registered done pulse, with the latched payload, once all lanes
// have reported. Overrun and payload-mismatch conditions are flagged sticky.
module lane_done_sync #(
  parameter int unsigned NumLane   = 4,
  parameter int unsigned NumVFU    = 3,
  parameter int unsigned NumOpQ    = 2,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned VregWidth = 5
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NumLane-1:0][NumVFU-1:0]                lane_vfus_done_i,
  input  logic [NumLane-1:0][NumVFU-1:0][IdWidth-1:0]   lane_vfus_done_id_i,
  input  logic [NumLane-1:0][NumVFU-1:0]                lane_vfus_use_vd_i,
  input  logic [NumLane-1:0][NumVFU-1:0][VregWidth-1:0] lane_vfus_vd_i,
  input  logic [NumLane-1:0][NumOpQ-1:0]                lane_op_access_done_i,
  input  logic [NumLane-1:0][NumOpQ-1:0][VregWidth-1:0] lane_op_access_vs_i,
  output logic [NumVFU-1:0]                             vfus_done_o,
  output logic [NumVFU-1:0][IdWidth-1:0]                vfus_done_id_o,
  output logic [NumVFU-1:0]                             vfus_use_vd_o,
  output logic [NumVFU-1:0][VregWidth-1:0]              vfus_vd_o,
  output logic [NumOpQ-1:0]                             op_access_done_o,
  output logic [NumOpQ-1:0][VregWidth-1:0]              op_access_vs_o,
  output logic [NumVFU+NumOpQ-1:0]                      err_overrun_o,
  output logic [NumVFU+NumOpQ-1:0]                      err_mismatch_o
);

  typedef enum logic {
    Idle,
    Collect
  } state_e;

  // ---------------------------------------------------------------------------
  // VFU channels: payload is {id, use_vd, vd}
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NumVFU; c++) begin : g_vfu
    state_e                 state_q, state_d;
    logic [NumLane-1:0]     pend_q, pend_d, pend_all, arr, counted;
    logic [IdWidth-1:0]     lat_id_q, ref_id, out_id_q;
    logic                   lat_use_q, ref_use, out_use_q;
    logic [VregWidth-1:0]   lat_vd_q, ref_vd, out_vd_q;
    logic                   overrun, mismatch, complete;
    logic                   done_q, ovr_q, mis_q;

    // Decode arrivals, pick the reference payload and evaluate completion.
    always_comb begin
      arr      = '0;
      ref_id   = lat_id_q;
      ref_use  = lat_use_q;
      ref_vd   = lat_vd_q;
      mismatch = 1'b0;
      for (int unsigned l = 0; l < NumLane; l++) begin
        arr[l] = lane_vfus_done_i[l][c];
      end
      // In Idle the reference is the lowest-indexed reporting lane; scanning
      // from the top lets the lowest index overwrite last.
      if (state_q == Idle) begin
        for (int unsigned i = 0; i < NumLane; i++) begin
          if (arr[NumLane-1-i]) begin
            ref_id  = lane_vfus_done_id_i[NumLane-1-i][c];
            ref_use = lane_vfus_use_vd_i[NumLane-1-i][c];
            ref_vd  = lane_vfus_vd_i[NumLane-1-i][c];
          end
        end
      end
      counted = arr & ~pend_q;
      overrun = |(arr & pend_q);
      for (int unsigned l = 0; l < NumLane; l++) begin
        if (counted[l] &&
            ((lane_vfus_done_id_i[l][c] != ref_id) ||
             (lane_vfus_use_vd_i[l][c] != ref_use) ||
             (ref_use && (lane_vfus_vd_i[l][c] != ref_vd)))) begin
          mismatch = 1'b1;
        end
      end
      pend_all = pend_q | counted;
      complete = &pend_all;
      pend_d   = complete ? '0 : pend_all;
      state_d  = complete ? Idle : ((|pend_all) ? Collect : state_q);
    end

    // Channel state, latched payload, registered outputs and sticky errors.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q   <= Idle;
        pend_q    <= '0;
        lat_id_q  <= '0;
        lat_use_q <= 1'b0;
        lat_vd_q  <= '0;
        done_q    <= 1'b0;
        out_id_q  <= '0;
        out_use_q <= 1'b0;
        out_vd_q  <= '0;
        ovr_q     <= 1'b0;
        mis_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        pend_q  <= pend_d;
        done_q  <= complete;
        if ((state_q == Idle) && (|arr)) begin
          lat_id_q  <= ref_id;
          lat_use_q <= ref_use;
          lat_vd_q  <= ref_vd;
        end
        if (complete) begin
          out_id_q  <= ref_id;
          out_use_q <= ref_use;
          out_vd_q  <= ref_vd;
        end
        if (overrun)  ovr_q <= 1'b1;
        if (mismatch) mis_q <= 1'b1;
      end
    end

    assign vfus_done_o[c]    = done_q;
    assign vfus_done_id_o[c] = out_id_q;
    assign vfus_use_vd_o[c]  = out_use_q;
    assign vfus_vd_o[c]      = out_vd_q;
    assign err_overrun_o[c]  = ovr_q;
    assign err_mismatch_o[c] = mis_q;
  end

  // ---------------------------------------------------------------------------
  // Operand-queue channels: payload is vs only
  // ---------------------------------------------------------------------------
  for (genvar q = 0; q < NumOpQ; q++) begin : g_opq
    state_e                 state_q, state_d;
    logic [NumLane-1:0]     pend_q, pend_d, pend_all, arr, counted;
    logic [VregWidth-1:0]   lat_vs_q, ref_vs, out_vs_q;
    logic                   overrun, mismatch, complete;
    logic                   done_q, ovr_q, mis_q;

    // Decode arrivals, pick the reference vs and evaluate completion.
    always_comb begin
      arr      = '0;
      ref_vs   = lat_vs_q;
      mismatch = 1'b0;
      for (int unsigned l = 0; l < NumLane; l++) begin
        arr[l] = lane_op_access_done_i[l][q];
      end
      if (state_q == Idle) begin
        for (int unsigned i = 0; i < NumLane; i++) begin
          if (arr[NumLane-1-i]) ref_vs = lane_op_access_vs_i[NumLane-1-i][q];
        end
      end
      counted = arr & ~pend_q;
      overrun = |(arr & pend_q);
      for (int unsigned l = 0; l < NumLane; l++) begin
        if (counted[l] && (lane_op_access_vs_i[l][q] != ref_vs)) mismatch = 1'b1;
      end
      pend_all = pend_q | counted;
      complete = &pend_all;
      pend_d   = complete ? '0 : pend_all;
      state_d  = complete ? Idle : ((|pend_all) ? Collect : state_q);
    end

    // Channel state, latched vs, registered outputs and sticky errors.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q  <= Idle;
        pend_q   <= '0;
        lat_vs_q <= '0;
        done_q   <= 1'b0;
        out_vs_q <= '0;
        ovr_q    <= 1'b0;
        mis_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        pend_q  <= pend_d;
        done_q  <= complete;
        if ((state_q == Idle) && (|arr)) lat_vs_q <= ref_vs;
        if (complete) out_vs_q <= ref_vs;
        if (overrun)  ovr_q <= 1'b1;
        if (mismatch) mis_q <= 1'b1;
      end
    end

    assign op_access_done_o[q]     = done_q;
    assign op_access_vs_o[q]       = out_vs_q;
    assign err_overrun_o[NumVFU+q]  = ovr_q;
    assign err_mismatch_o[NumVFU+q] = mis_q;
  end

endmodule

// File: tb/tb_lane_done_sync.sv
// Scoreboard bench for lane_done_sync: a transaction-level model predicts
// pulses and error flags; a monitor compares whenever the DUT presents output.
module tb_lane_done_sync;
  localparam int NL = 4, NV = 3, NQ = 2, NCH = NV + NQ, IW = 3, VW = 5;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          use_vd;
    logic [VW-1:0] vd;
  } pl_t;
  typedef struct {int due; int ch; pl_t pl;} pulse_t;
  typedef struct {int due; bit rst; logic [NCH-1:0] ovr; logic [NCH-1:0] mis;} snap_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NL-1:0][NV-1:0]         lane_vfus_done_i = '0;
  logic [NL-1:0][NV-1:0][IW-1:0] lane_vfus_done_id_i = '0;
  logic [NL-1:0][NV-1:0]         lane_vfus_use_vd_i = '0;
  logic [NL-1:0][NV-1:0][VW-1:0] lane_vfus_vd_i = '0;
  logic [NL-1:0][NQ-1:0]         lane_op_access_done_i = '0;
  logic [NL-1:0][NQ-1:0][VW-1:0] lane_op_access_vs_i = '0;
  logic [NV-1:0]                 vfus_done_o;
  logic [NV-1:0][IW-1:0]         vfus_done_id_o;
  logic [NV-1:0]                 vfus_use_vd_o;
  logic [NV-1:0][VW-1:0]         vfus_vd_o;
  logic [NQ-1:0]                 op_access_done_o;
  logic [NQ-1:0][VW-1:0]         op_access_vs_o;
  logic [NCH-1:0]                err_overrun_o, err_mismatch_o;

  lane_done_sync #(
    .NumLane(NL), .NumVFU(NV), .NumOpQ(NQ), .IdWidth(IW), .VregWidth(VW)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .lane_vfus_done_i      (lane_vfus_done_i),
    .lane_vfus_done_id_i   (lane_vfus_done_id_i),
    .lane_vfus_use_vd_i    (lane_vfus_use_vd_i),
    .lane_vfus_vd_i        (lane_vfus_vd_i),
    .lane_op_access_done_i (lane_op_access_done_i),
    .lane_op_access_vs_i   (lane_op_access_vs_i),
    .vfus_done_o           (vfus_done_o),
    .vfus_done_id_o        (vfus_done_id_o),
    .vfus_use_vd_o         (vfus_use_vd_o),
    .vfus_vd_o             (vfus_vd_o),
    .op_access_done_o      (op_access_done_o),
    .op_access_vs_o        (op_access_vs_o),
    .err_overrun_o         (err_overrun_o),
    .err_mismatch_o        (err_mismatch_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Stimulus for the upcoming edge, indexed [channel][lane]
  bit  s_done[NCH][NL];
  pl_t s_pl[NCH][NL];

  // Reference model: which lanes have reported in the open transaction
  bit             seen[NCH][NL];
  bit             active[NCH];
  pl_t            refp[NCH];
  logic [NCH-1:0] m_ovr = '0, m_mis = '0;
  pl_t            cur[NCH];

  pulse_t pq[$];
  snap_t  sq[$];

  function automatic pl_t mk(int id, int u, int vd);
    pl_t p;
    p.id = IW'(id); p.use_vd = u[0]; p.vd = VW'(vd);
    return p;
  endfunction

  // Whether a lane's report agrees with the reference under channel rules
  function automatic bit agrees(int ch, pl_t a, pl_t r);
    if (ch >= NV) return a.vd == r.vd;
    return (a.id == r.id) && (a.use_vd == r.use_vd) && (!r.use_vd || a.vd == r.vd);
  endfunction

  function automatic bit out_eq(int ch, pl_t a, pl_t b);
    if (ch >= NV) return a.vd == b.vd;
    return a == b;
  endfunction

  task automatic clr();
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < NL; l++) s_done[c][l] = 1'b0;
  endtask

  // Apply stimulus, advance the model, then let one clock edge pass
  task automatic step(bit rn);
    snap_t s;
    rst_ni = rn;
    for (int l = 0; l < NL; l++) begin
      for (int c = 0; c < NV; c++) begin
        lane_vfus_done_i[l][c]    = s_done[c][l];
        lane_vfus_done_id_i[l][c] = s_pl[c][l].id;
        lane_vfus_use_vd_i[l][c]  = s_pl[c][l].use_vd;
        lane_vfus_vd_i[l][c]      = s_pl[c][l].vd;
      end
      for (int q = 0; q < NQ; q++) begin
        lane_op_access_done_i[l][q] = s_done[NV+q][l];
        lane_op_access_vs_i[l][q]   = s_pl[NV+q][l].vd;
      end
    end
    if (!rn) begin
      m_ovr = '0; m_mis = '0;
      for (int c = 0; c < NCH; c++) begin
        active[c] = 1'b0;
        for (int l = 0; l < NL; l++) seen[c][l] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int  low;
        bit  all;
        low = -1;
        for (int l = NL - 1; l >= 0; l--) if (s_done[c][l]) low = l;
        if (low < 0) continue;
        if (!active[c]) begin
          refp[c] = s_pl[c][low];
          active[c] = 1'b1;
        end
        for (int l = 0; l < NL; l++) begin
          if (!s_done[c][l]) continue;
          if (seen[c][l]) m_ovr[c] = 1'b1;
          else begin
            seen[c][l] = 1'b1;
            if (!agrees(c, s_pl[c][l], refp[c])) m_mis[c] = 1'b1;
          end
        end
        all = 1'b1;
        for (int l = 0; l < NL; l++) all &= seen[c][l];
        if (all) begin
          pulse_t p;
          p.due = cyc + 1; p.ch = c; p.pl = refp[c];
          pq.push_back(p);
          active[c] = 1'b0;
          for (int l = 0; l < NL; l++) seen[c][l] = 1'b0;
        end
      end
    end
    s.due = cyc + 1; s.rst = !rn; s.ovr = m_ovr; s.mis = m_mis;
    sq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    clr();
    repeat (n) step(1'b1);
  endtask

  task automatic all_lanes(int ch, pl_t p);
    clr();
    for (int l = 0; l < NL; l++) begin s_done[ch][l] = 1'b1; s_pl[ch][l] = p; end
  endtask

  function automatic pl_t act_pl(int ch);
    pl_t p;
    if (ch < NV) begin
      p.id = vfus_done_id_o[ch]; p.use_vd = vfus_use_vd_o[ch]; p.vd = vfus_vd_o[ch];
    end else begin
      p = '0; p.vd = op_access_vs_o[ch-NV];
    end
    return p;
  endfunction

  // Monitor: compare DUT outputs with scoreboard expectations each cycle
  initial begin
    pl_t held[NCH];
    for (int c = 0; c < NCH; c++) held[c] = '0;
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].due <= cyc) begin
        snap_t s;
        s = sq.pop_front();
        if (s.due != cyc) continue;
        if (s.rst) for (int c = 0; c < NCH; c++) held[c] = '0;
        checks++;
        if (err_overrun_o !== s.ovr) begin
          failures++;
          $display("FAIL err_overrun cyc=%0d got=%b want=%b", cyc, err_overrun_o, s.ovr);
        end
        checks++;
        if (err_mismatch_o !== s.mis) begin
          failures++;
          $display("FAIL err_mismatch cyc=%0d got=%b want=%b", cyc, err_mismatch_o, s.mis);
        end
        for (int c = 0; c < NCH; c++) begin
          int   idx;
          logic d;
          idx = -1;
          for (int i = 0; i < pq.size(); i++) if (pq[i].ch == c && pq[i].due == cyc) idx = i;
          d = (c < NV) ? vfus_done_o[c] : op_access_done_o[c-NV];
          checks++;
          if (d !== (idx >= 0)) begin
            failures++;
            $display("FAIL done ch=%0d cyc=%0d got=%b want=%b", c, cyc, d, idx >= 0);
          end
          if (idx >= 0) begin
            held[c] = pq[idx].pl;
            pq.delete(idx);
          end
          checks++;
          if (!out_eq(c, act_pl(c), held[c])) begin
            failures++;
            $display("FAIL payload ch=%0d cyc=%0d got=%h want=%h", c, cyc, act_pl(c), held[c]);
          end
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin
      active[c] = 1'b0;
      cur[c] = '0;
      for (int l = 0; l < NL; l++) begin seen[c][l] = 1'b0; s_pl[c][l] = '0; end
    end
    clr();
    step(1'b0);
    step(1'b0);
    idle(2);

    // All lanes together on VFU0
    all_lanes(0, mk(5, 1, 3)); step(1'b1); idle(3);

    // Staggered OpQ1 reports: lane 0, then 1+2, then 3
    clr(); for (int l = 0; l < NL; l++) s_pl[NV+1][l] = mk(0, 0, 7);
    s_done[NV+1][0] = 1; step(1'b1); idle(1);
    s_done[NV+1][1] = 1; s_done[NV+1][2] = 1; step(1'b1); idle(2);
    s_done[NV+1][3] = 1; step(1'b1); idle(3);

    // Overrun on VFU1: lane 2 twice before the others
    clr(); for (int l = 0; l < NL; l++) s_pl[1][l] = mk(3, 1, 9);
    s_done[1][2] = 1; step(1'b1); idle(1);
    s_done[1][2] = 1; step(1'b1); idle(1);
    for (int l = 0; l < NL; l++) s_done[1][l] = (l != 2); step(1'b1); idle(3);

    // Mismatch on VFU2: lane 3 disagrees on id
    all_lanes(2, mk(2, 1, 4)); s_pl[2][3] = mk(4, 1, 4); step(1'b1); idle(3);

    // Back-to-back completions on VFU0
    all_lanes(0, mk(1, 0, 6)); step(1'b1);
    all_lanes(0, mk(2, 1, 6)); step(1'b1); idle(3);

    // Reset mid-collection; reports during reset are ignored
    clr(); for (int l = 0; l < NL; l++) s_pl[2][l] = mk(6, 1, 12);
    s_done[2][0] = 1; s_done[2][1] = 1; step(1'b1);
    all_lanes(0, mk(7, 1, 1)); step(1'b0);
    clr(); s_done[2][2] = 1; s_done[2][3] = 1; step(1'b1); idle(2);
    s_done[2][0] = 1; s_done[2][1] = 1; step(1'b1); idle(3);

    // Randomized traffic with occasional overruns and corrupted payloads
    for (int n = 0; n < 800; n++) begin
      clr();
      for (int c = 0; c < NCH; c++) begin
        if (!active[c]) cur[c] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31));
        for (int l = 0; l < NL; l++) begin
          if (!seen[c][l]) s_done[c][l] = ($urandom_range(0, 99) < 35);
          else             s_done[c][l] = ($urandom_range(0, 199) < 2);
          s_pl[c][l] = cur[c];
          if ($urandom_range(0, 39) == 0)
            s_pl[c][l] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31));
        end
      end
      step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
    end
    idle(4);
    @(negedge clk);
    #1;
    checks++;
    if (pq.size() != 0) begin
      failures++;
      $display("FAIL leftover_pulses got=%0d want=0", pq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
